// File: rtl/pipe_stage_buf.sv
// Elastic valid/ready pipeline register with a DEPTH-entry in-order buffer.
// Optional perf counters are enabled with `define PIPE_STAGE_BUF_PERF_EN.
module pipe_stage_buf #(
  parameter int                 DATA_W    = 32,
  parameter int                 SIDE_W    = 1,
  parameter int                 DEPTH     = 2,
  parameter logic [DATA_W-1:0]  NOP_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         up_valid,
  input  logic [DATA_W-1:0]            up_data,
  input  logic [SIDE_W-1:0]            up_side,
  output logic                         up_ready,
  output logic                         dn_valid,
  output logic [DATA_W-1:0]            dn_data,
  input  logic                         dn_ready,
  output logic [SIDE_W-1:0]            side_q,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  bubble_cnt
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic              push, pop;

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign up_ready = (cnt_q < CW'(DEPTH));
  assign dn_valid = (cnt_q != '0);
  assign dn_data  = dn_valid ? mem_q[rd_q] : NOP_VALUE;
  assign count    = cnt_q;

  assign push = up_valid & up_ready & ~flush;
  assign pop  = dn_valid & dn_ready & ~flush;

  always_comb begin
    cnt_d = cnt_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (flush) begin
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
    end else begin
      if (push) wr_d = inc(wr_q);
      if (pop)  rd_d = inc(rd_q);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      side_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      if (flush)     side_q <= '0;
      else if (push) side_q <= up_side;
    end
  end

  // Payload storage needs no reset; validity lives in cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= up_data;
  end

`ifdef PIPE_STAGE_BUF_PERF_EN
  logic [31:0] stall_q, bubble_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      if (dn_valid && !dn_ready && stall_q != '1)
        stall_q <= stall_q + 32'd1;
      if (!dn_valid && dn_ready && bubble_q != '1)
        bubble_q <= bubble_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
`else
  assign stall_cnt  = 32'h0;
  assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: vector table, scoreboard monitor and corner sequences.
// DUT a: DEPTH=2, NOP=0. DUT b: DEPTH=3, NOP=DEADBEEF for wrap/order.
module tb_pipe_stage_buf;

  typedef struct {
    logic        uv;
    logic [31:0] ud;
    logic        us;
    logic        dr;
    logic        fl;
    logic [1:0]  cnt;
    logic        dv;
    logic [31:0] dd;
    logic        ur;
    logic        sd;
  } vec_t;

  logic        clk;
  logic        rst;

  logic        a_fl, a_uv, a_us, a_ur, a_dv, a_dr, a_side;
  logic [31:0] a_ud, a_dd, a_stall, a_bubble;
  logic [1:0]  a_cnt;

  logic        b_fl, b_uv, b_us, b_ur, b_dv, b_dr, b_side;
  logic [31:0] b_ud, b_dd, b_stall, b_bubble;
  logic [1:0]  b_cnt;

  int checks = 0;
  int fails  = 0;
  bit mon_en = 0;

  logic [31:0] aq[$];
  logic        m_side;

  vec_t tbl [18];

  pipe_stage_buf #(
    .DATA_W(32), .SIDE_W(1), .DEPTH(2), .NOP_VALUE(32'h0)
  ) u_a (
    .clk(clk), .rst(rst), .flush(a_fl),
    .up_valid(a_uv), .up_data(a_ud), .up_side(a_us), .up_ready(a_ur),
    .dn_valid(a_dv), .dn_data(a_dd), .dn_ready(a_dr),
    .side_q(a_side), .count(a_cnt),
    .stall_cnt(a_stall), .bubble_cnt(a_bubble)
  );

  pipe_stage_buf #(
    .DATA_W(32), .SIDE_W(1), .DEPTH(3), .NOP_VALUE(32'hDEAD_BEEF)
  ) u_b (
    .clk(clk), .rst(rst), .flush(b_fl),
    .up_valid(b_uv), .up_data(b_ud), .up_side(b_us), .up_ready(b_ur),
    .dn_valid(b_dv), .dn_data(b_dd), .dn_ready(b_dr),
    .side_q(b_side), .count(b_cnt),
    .stall_cnt(b_stall), .bubble_cnt(b_bubble)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit uv, int ud, bit us, bit dr, bit fl,
                              int cnt, bit dv, int dd, bit ur, bit sd);
    vec_t r;
    r.uv = uv; r.ud = 32'(ud); r.us = us; r.dr = dr; r.fl = fl;
    r.cnt = 2'(cnt); r.dv = dv; r.dd = 32'(dd); r.ur = ur; r.sd = sd;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for DUT a: compare outputs mid-cycle, then advance model.
  always @(negedge clk) begin
    if (!rst) begin
      aq.delete();
      m_side = 1'b0;
    end else if (mon_en) begin : mon
      logic        edv;
      logic [31:0] edd;
      bit          ps, pp;
      edv = (aq.size() != 0);
      edd = edv ? aq[0] : 32'h0;
      chk("sb_dn_valid", 32'(a_dv), 32'(edv));
      chk("sb_dn_data", a_dd, edd);
      chk("sb_up_ready", 32'(a_ur), 32'(aq.size() < 2));
      chk("sb_count", 32'(a_cnt), 32'(aq.size()));
      chk("sb_side", 32'(a_side), 32'(m_side));
      ps = a_uv && (aq.size() < 2) && !a_fl;
      pp = edv && a_dr && !a_fl;
      if (a_fl) begin
        aq.delete();
        m_side = 1'b0;
      end else begin
        if (pp) void'(aq.pop_front());
        if (ps) begin
          aq.push_back(a_ud);
          m_side = a_us;
        end
      end
    end
  end

  initial begin : main
    int          nxt, got, bcnt;
    bit          ps, pp;
    logic [31:0] bq[$];

    tbl[0]  = mk(1, 'h11, 0, 1, 0, 1, 1, 'h11, 1, 0);
    tbl[1]  = mk(1, 'h22, 0, 1, 0, 1, 1, 'h22, 1, 0);
    tbl[2]  = mk(1, 'h33, 0, 1, 0, 1, 1, 'h33, 1, 0);
    tbl[3]  = mk(0, 0,    0, 1, 0, 0, 0, 0,    1, 0);
    tbl[4]  = mk(1, 'hA1, 0, 0, 0, 1, 1, 'hA1, 1, 0);
    tbl[5]  = mk(1, 'hA2, 0, 0, 0, 2, 1, 'hA1, 0, 0);
    tbl[6]  = mk(1, 'hA3, 0, 0, 0, 2, 1, 'hA1, 0, 0);
    tbl[7]  = mk(1, 'hA3, 0, 1, 0, 1, 1, 'hA2, 1, 0);
    tbl[8]  = mk(1, 'hA3, 0, 1, 0, 1, 1, 'hA3, 1, 0);
    tbl[9]  = mk(0, 0,    0, 1, 0, 0, 0, 0,    1, 0);
    tbl[10] = mk(1, 'hB1, 1, 0, 0, 1, 1, 'hB1, 1, 1);
    tbl[11] = mk(1, 'hB2, 1, 0, 0, 2, 1, 'hB1, 0, 1);
    tbl[12] = mk(1, 'hB3, 0, 1, 1, 0, 0, 0,    1, 0);
    tbl[13] = mk(0, 0,    0, 1, 0, 0, 0, 0,    1, 0);
    tbl[14] = mk(1, 'hC1, 1, 0, 0, 1, 1, 'hC1, 1, 1);
    tbl[15] = mk(1, 'hC2, 0, 1, 1, 0, 0, 0,    1, 0);
    tbl[16] = mk(1, 'hC3, 0, 0, 0, 1, 1, 'hC3, 1, 0);
    tbl[17] = mk(0, 0,    0, 1, 0, 0, 0, 0,    1, 0);

    rst = 1'b0;
    a_fl = 0; a_uv = 0; a_ud = '0; a_us = 0; a_dr = 0;
    b_fl = 0; b_uv = 0; b_ud = '0; b_us = 0; b_dr = 0;
    #1;
    chk("rst_dn_valid", 32'(a_dv), 32'h0);
    chk("rst_dn_data", a_dd, 32'h0);
    chk("rst_up_ready", 32'(a_ur), 32'h1);
    chk("rst_count", 32'(a_cnt), 32'h0);
    chk("rst_side", 32'(a_side), 32'h0);
    chk("rst_b_nop", b_dd, 32'hDEAD_BEEF);
    #11 rst = 1'b1;
    mon_en = 1;
    step();

    for (int i = 0; i < 18; i++) begin
      a_uv = tbl[i].uv; a_ud = tbl[i].ud; a_us = tbl[i].us;
      a_dr = tbl[i].dr; a_fl = tbl[i].fl;
      step();
      chk($sformatf("v%0d_count", i), 32'(a_cnt), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_dn_valid", i), 32'(a_dv), 32'(tbl[i].dv));
      chk($sformatf("v%0d_dn_data", i), a_dd, tbl[i].dd);
      chk($sformatf("v%0d_up_ready", i), 32'(a_ur), 32'(tbl[i].ur));
      chk($sformatf("v%0d_side", i), 32'(a_side), 32'(tbl[i].sd));
    end
    a_fl = 0;

    // Asynchronous reset with two entries held.
    a_uv = 1; a_ud = 32'hE1; a_us = 0; a_dr = 0;
    step();
    a_ud = 32'hE2;
    step();
    chk("pre_rst_count", 32'(a_cnt), 32'h2);
    a_uv = 0;
    #2 rst = 1'b0;
    #1;
    chk("async_dn_valid", 32'(a_dv), 32'h0);
    chk("async_dn_data", a_dd, 32'h0);
    chk("async_up_ready", 32'(a_ur), 32'h1);
    chk("async_count", 32'(a_cnt), 32'h0);
    chk("async_stall", a_stall, 32'h0);
    chk("async_bubble", a_bubble, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Sticky sideband and perf counters.
    a_uv = 1; a_ud = 32'hD1; a_us = 1; a_dr = 0;
    step();
    a_ud = 32'hD2;
    step();
    a_uv = 0; a_us = 0;
    repeat (5) step();
    chk("hold_count", 32'(a_cnt), 32'h2);
    chk("hold_head", a_dd, 32'hD1);
`ifdef PIPE_STAGE_BUF_PERF_EN
    chk("stall_cnt", a_stall, 32'd6);
`else
    chk("stall_cnt", a_stall, 32'd0);
`endif
    a_dr = 1;
    repeat (2) step();
    repeat (3) step();
    a_dr = 0;
    chk("bubble_side", 32'(a_side), 32'h1);
    chk("bubble_dn_valid", 32'(a_dv), 32'h0);
    chk("bubble_dn_data", a_dd, 32'h0);
`ifdef PIPE_STAGE_BUF_PERF_EN
    chk("bubble_cnt", a_bubble, 32'd3);
`else
    chk("bubble_cnt", a_bubble, 32'd0);
`endif
    step();

    // DEPTH=3 wrap with random backpressure; order must hold.
    nxt = 1; got = 0; bcnt = 0;
    for (int cyc = 0; cyc < 200 && (nxt <= 7 || bcnt > 0); cyc++) begin
      b_uv = (nxt <= 7);
      b_ud = 32'(nxt);
      b_dr = 1'($urandom_range(0, 1));
      chk("b_up_ready", 32'(b_ur), 32'(bcnt < 3));
      chk("b_dn_valid", 32'(b_dv), 32'(bcnt > 0));
      ps = b_uv && (bcnt < 3);
      pp = (bcnt > 0) && b_dr;
      if (pp) begin
        chk("b_order", b_dd, bq[0]);
        void'(bq.pop_front());
        got++;
      end
      if (ps) begin
        bq.push_back(32'(nxt));
        nxt++;
      end
      bcnt = bcnt + int'(ps) - int'(pp);
      step();
    end
    b_uv = 0; b_dr = 0;
    chk("b_drained", 32'(got), 32'd7);
    chk("b_empty_count", 32'(b_cnt), 32'h0);
    chk("b_empty_nop", b_dd, 32'hDEAD_BEEF);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
